// File: rtl/aes_tot_pkg.sv
// aes_tot_pkg: command codes, op encoding and payload layout shared by the AES total wrapper and its host
package aes_tot_pkg;
  localparam int PAYLOAD_W = 1024;
  localparam int ENC_AUTH_BIT = 521;
  localparam int COUNTER_LSB = 393;
  localparam int KEY_LSB = 137;
  localparam int KEYLEN_BIT = 136;
  localparam int FINAL_SIZE_LSB = 128;
  localparam int BLOCK_LSB = 0;
  localparam logic [31:0] CMD_READ = 32'h0;
  localparam logic [31:0] CMD_INIT = 32'h1;
  localparam logic [31:0] CMD_NEXT = 32'h2;
  localparam logic [31:0] CMD_FINAL = 32'h3;
  localparam logic [31:0] CMD_WRITE = 32'h4;
  typedef enum logic [1:0] {OP_ILLEGAL, OP_INIT, OP_NEXT, OP_FINAL} op_e;
  typedef enum logic [1:0] {PH_LOAD, PH_COMPUTE, PH_FETCH} phase_e;
  function automatic logic [PAYLOAD_W-1:0] pack_payload(
    input logic enc_auth,
    input logic [127:0] counter,
    input logic [255:0] key,
    input logic keylen,
    input logic [7:0] final_size,
    input logic [127:0] block_i
  );
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    p[ENC_AUTH_BIT] = enc_auth;
    p[COUNTER_LSB +: 128] = counter;
    p[KEY_LSB +: 256] = key;
    p[KEYLEN_BIT] = keylen;
    p[FINAL_SIZE_LSB +: 8] = final_size;
    p[BLOCK_LSB +: 128] = block_i;
    return p;
  endfunction
  // compute commands carry the op code directly (INIT=1, NEXT=2, FINAL=3)
  function automatic logic [31:0] phase_cmd(input phase_e ph, input logic [1:0] op);
    return ph == PH_LOAD ? CMD_READ : ph == PH_FETCH ? CMD_WRITE : {30'd0, op};
  endfunction
endpackage

// File: rtl/aes_tot_timeout_cnt.sv
// aes_tot_timeout_cnt: wait-state watchdog
// ports: clk, reset (async, active-high), clr (state changed), en (in a wait state),
//        expired (high in the cycle whose increment would bring the count to LIMIT)
module aes_tot_timeout_cnt #(
  parameter int LIMIT = 1024,
  parameter int CNT_W = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  assign expired = en && cnt == CNT_W'(LIMIT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/aes_tot_host_ctrl.sv
// aes_tot_host_ctrl: host-side initiator running READ / COMPUTE / WRITE transactions against the AES total wrapper
// ports: job_* (one job in, valid/ready), result_* (128-bit result out, valid/ready, err on abort),
//        arm_to_fpga_* / fpga_to_arm_* (command, done handshake, load and fetch data channels)
module aes_tot_host_ctrl
  import aes_tot_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic job_valid,
  output logic job_ready,
  input  logic [1:0] job_op,
  input  logic job_enc_auth,
  input  logic [127:0] job_counter,
  input  logic [255:0] job_key,
  input  logic job_keylen,
  input  logic [7:0] job_final_size,
  input  logic [127:0] job_block_i,
  output logic result_valid,
  input  logic result_ready,
  output logic [127:0] result_data,
  output logic result_err,
  output logic [31:0] arm_to_fpga_cmd,
  output logic arm_to_fpga_cmd_valid,
  input  logic fpga_to_arm_done,
  output logic fpga_to_arm_done_read,
  output logic arm_to_fpga_data_valid,
  input  logic arm_to_fpga_data_ready,
  output logic [1023:0] arm_to_fpga_data,
  input  logic fpga_to_arm_data_valid,
  output logic fpga_to_arm_data_ready,
  input  logic [1023:0] fpga_to_arm_data
);
  typedef enum logic [2:0] {IDLE, ISSUE, XFER, WAIT_DONE, ACK, DONE_LOW, RESULT} state_e;
  state_e state, state_n;
  phase_e phase, phase_n;
  logic [1:0] op;
  logic waiting, expired, fetch_hs, accept;
  assign waiting = state inside {XFER, WAIT_DONE, DONE_LOW};
  assign accept = state == IDLE && job_valid;
  assign fetch_hs = state == XFER && phase == PH_FETCH && fpga_to_arm_data_ready && fpga_to_arm_data_valid;
  aes_tot_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_timeout (
    .clk(clk),
    .reset(reset),
    .clr(state_n != state),
    .en(waiting),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      phase <= PH_LOAD;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  always_comb begin
    state_n = state;
    phase_n = phase;
    case (state)
      IDLE: if (job_valid) begin
        state_n = job_op == OP_ILLEGAL ? RESULT : ISSUE;
        phase_n = PH_LOAD;
      end
      ISSUE: state_n = phase == PH_COMPUTE ? WAIT_DONE : XFER;
      XFER: if (phase == PH_LOAD ? arm_to_fpga_data_ready : fetch_hs) state_n = WAIT_DONE;
      WAIT_DONE: if (fpga_to_arm_done) state_n = ACK;
      ACK: state_n = DONE_LOW;
      // done lags the wrapper by a cycle; waiting for it to fall keeps a stale done from ending the next transaction
      DONE_LOW: if (!fpga_to_arm_done) begin
        state_n = phase == PH_FETCH ? RESULT : ISSUE;
        phase_n = phase == PH_LOAD ? PH_COMPUTE : PH_FETCH;
      end
      RESULT: if (result_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (expired) state_n = RESULT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op <= '0;
      job_ready <= 1'b1;
      arm_to_fpga_cmd <= '0;
      arm_to_fpga_cmd_valid <= 1'b0;
      fpga_to_arm_done_read <= 1'b0;
      arm_to_fpga_data_valid <= 1'b0;
      arm_to_fpga_data <= '0;
      fpga_to_arm_data_ready <= 1'b0;
      result_valid <= 1'b0;
      result_data <= '0;
      result_err <= 1'b0;
    end else begin
      job_ready <= state_n == IDLE;
      arm_to_fpga_cmd_valid <= state_n == ISSUE;
      if (state_n == ISSUE) arm_to_fpga_cmd <= phase_cmd(phase_n, op);
      fpga_to_arm_done_read <= state_n == ACK;
      result_valid <= state_n == RESULT;
      arm_to_fpga_data_valid <= (state == ISSUE && phase == PH_LOAD) ? 1'b1 :
                                ((state == WAIT_DONE && fpga_to_arm_done) || expired) ? 1'b0 : arm_to_fpga_data_valid;
      // one-cycle ready pulse, raised the cycle after fetch valid is first seen
      fpga_to_arm_data_ready <= state == XFER && phase == PH_FETCH && fpga_to_arm_data_valid &&
                                !fpga_to_arm_data_ready && !expired;
      if (accept) begin
        op <= job_op;
        arm_to_fpga_data <= pack_payload(job_enc_auth, job_counter, job_key, job_keylen, job_final_size, job_block_i);
        result_data <= '0;
        result_err <= job_op == OP_ILLEGAL;
      end
      if (fetch_hs) result_data <= fpga_to_arm_data[127:0];
      if (expired) begin
        result_data <= '0;
        result_err <= 1'b1;
      end
    end
endmodule
